// File: rtl/gearbox_20to16.sv
`default_nettype none
// ============================================================================
//  Module      : gearbox_20to16
//  Description : Receive-side gearbox. Accepts IN_W-bit words and emits
//                OUT_W-bit words, LSB-first on both sides, through an
//                internal shift buffer whose bit 0 is the oldest bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module gearbox_20to16 #(
    parameter int IN_W     = 20,
    parameter int OUT_W    = 16,
    parameter int BUF_BITS = 80
) (
    input  logic             clk,
    input  logic             res,
    input  logic [IN_W-1:0]  data_in,
    input  logic             shift_in,
    output logic             full,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    input  logic             shift_out
);

    localparam int c_CNT_W = $clog2(BUF_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_FULL_TH = c_CNT_W'(BUF_BITS - IN_W);
    localparam logic [c_CNT_W-1:0] c_IN_CNT  = c_CNT_W'(IN_W);
    localparam logic [c_CNT_W-1:0] c_OUT_CNT = c_CNT_W'(OUT_W);

    logic [BUF_BITS-1:0] r_buf;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_push_acc;
    logic                w_pop_acc;
    logic [BUF_BITS-1:0] w_din_ext;
    logic [BUF_BITS-1:0] w_buf_pop;
    logic [c_CNT_W-1:0]  w_cnt_pop;
    logic [BUF_BITS-1:0] w_buf_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;

    // Status flags come from registered state only, so no input reaches an output.
    assign full      = (r_cnt > c_FULL_TH);
    assign valid_out = (r_cnt >= c_OUT_CNT);
    assign data_out  = r_buf[OUT_W-1:0];

    assign w_push_acc = shift_in & ~full;
    assign w_pop_acc  = shift_out & valid_out;
    assign w_din_ext  = {{(BUF_BITS - IN_W){1'b0}}, data_in};

    // Next-state: pop first (shift out oldest bits), then append the new word
    // right above the remaining valid bits. Bits above the count are always
    // zero, so an OR is enough to merge the new word in.
    always_comb begin
        w_buf_pop = r_buf;
        w_cnt_pop = r_cnt;
        if (w_pop_acc) begin
            w_buf_pop = r_buf >> OUT_W;
            w_cnt_pop = r_cnt - c_OUT_CNT;
        end
        w_buf_nxt = w_buf_pop;
        w_cnt_nxt = w_cnt_pop;
        if (w_push_acc) begin
            w_buf_nxt = w_buf_pop | (w_din_ext << w_cnt_pop);
            w_cnt_nxt = w_cnt_pop + c_IN_CNT;
        end
    end

    // Buffer and fill-count registers; reset discards any buffered data.
    always_ff @(posedge clk) begin
        if (res) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            r_buf <= w_buf_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gearbox_20to16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gearbox_20to16
//  Description : Self-checking bench for gearbox_20to16. A bit-queue model
//                predicts flags and output word for every cycle; a separate
//                monitor compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gearbox_20to16;

    logic        clk;
    logic        res;
    logic [19:0] data_in;
    logic        shift_in;
    logic        full;
    logic [15:0] data_out;
    logic        valid_out;
    logic        shift_out;

    typedef struct packed {
        logic        full;
        logic        valid;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    bit   mq[$];
    int   n_assert;
    int   n_fail;
    logic [19:0] ctr;

    gearbox_20to16 dut (
        .clk      (clk),
        .res      (res),
        .data_in  (data_in),
        .shift_in (shift_in),
        .full     (full),
        .data_out (data_out),
        .valid_out(valid_out),
        .shift_out(shift_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: record what the DUT must show this cycle, drive
    // the request, then advance the bit-level model by the accepted transfers.
    task automatic step(input logic r, input logic si, input logic so, input logic [19:0] din);
        exp_t e;
        int   n;
        bit   b;
        logic pop_ok;
        logic push_ok;
        n       = mq.size();
        e.full  = (n > 60);
        e.valid = (n >= 16);
        e.data  = '0;
        for (int i = 0; i < 16; i++)
            if (i < n) e.data[i] = mq[i];
        exp_q.push_back(e);
        res       = r;
        shift_in  = si;
        shift_out = so;
        data_in   = din;
        pop_ok  = !r && so && (n >= 16);
        push_ok = !r && si && (n <= 60);
        if (r) begin
            mq.delete();
        end else begin
            if (pop_ok)
                for (int i = 0; i < 16; i++) b = mq.pop_front();
            if (push_ok)
                for (int i = 0; i < 20; i++) mq.push_back(din[i]);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: mid-cycle, compare the DUT's presented state to the expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (full !== e.full) begin
                n_fail++;
                $display("FAIL full: got %b expected %b at %0t", full, e.full, $time);
            end
            n_assert++;
            if (valid_out !== e.valid) begin
                n_fail++;
                $display("FAIL valid_out: got %b expected %b at %0t", valid_out, e.valid, $time);
            end
            n_assert++;
            if (data_out !== e.data) begin
                n_fail++;
                $display("FAIL data_out: got %h expected %h at %0t", data_out, e.data, $time);
            end
        end
    end

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        ctr       = '0;
        res       = 1'b1;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        data_in   = '0;
        @(posedge clk);
        #1;

        // Reset held with both requests active
        repeat (3) step(1'b1, 1'b1, 1'b1, 20'hFFFFF);

        // Ordering: two pushes, two pops, residual 8 bits stay
        step(1'b0, 1'b1, 1'b0, 20'h54321);
        step(1'b0, 1'b1, 1'b0, 20'hA9876);
        step(1'b0, 1'b0, 1'b1, 20'h0);
        step(1'b0, 1'b0, 1'b1, 20'h0);
        step(1'b0, 1'b0, 1'b1, 20'h0);
        step(1'b0, 1'b0, 1'b0, 20'h0);

        // Fill to 80 bits, ignored push at full, drain completely
        step(1'b1, 1'b0, 1'b0, 20'h0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 20'($urandom()));
        step(1'b0, 1'b1, 1'b0, 20'hFFFFF);
        repeat (5) step(1'b0, 1'b0, 1'b1, 20'h0);
        step(1'b0, 1'b0, 1'b0, 20'h0);

        // Simultaneous push+pop at full (pop only) and at 16 bits (both)
        step(1'b1, 1'b0, 1'b0, 20'h0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 20'($urandom()));
        step(1'b0, 1'b1, 1'b1, 20'($urandom()));
        repeat (3) step(1'b0, 1'b0, 1'b1, 20'h0);
        step(1'b0, 1'b1, 1'b1, 20'hBEEF5);
        step(1'b0, 1'b0, 1'b0, 20'h0);

        // Continuous counter stream, push and pop requested every cycle
        step(1'b1, 1'b0, 1'b0, 20'h0);
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b1, 1'b1, ctr);
            ctr = ctr + 20'd1;
        end

        // Mid-operation reset at 44 bits with a simultaneous push
        step(1'b1, 1'b0, 1'b0, 20'h0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 20'($urandom()));
        step(1'b0, 1'b0, 1'b1, 20'h0);
        step(1'b1, 1'b1, 1'b0, 20'($urandom()));
        step(1'b0, 1'b1, 1'b0, 20'h12345);
        step(1'b0, 1'b0, 1'b1, 20'h0);
        step(1'b0, 1'b0, 1'b0, 20'h0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0),
                 20'($urandom()));
        end
        step(1'b0, 1'b0, 1'b0, 20'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
